guess_history: RTL and testbench

//  Parametrised register bank with per-write enable: the next generation of the 4-bit enabled register.

---
 rtl/guess_history.sv | 105 ++++++++++
 tb/tb_guess_history.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/guess_history.sv
// guess_history: bank of DEPTH enabled registers holding Mastermind guesses in
// push order. Offers indexed read-back (index 0 = oldest), the newest entry,
// occupancy flags and a sticky overflow flag. FULL_MODE picks whether a push
// while full is dropped (0) or evicts the oldest entry (1).
module guess_history #(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 8,
    parameter bit FULL_MODE = 1'b0,
    localparam int CW       = $clog2(DEPTH + 1),
    localparam int IW       = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_d,
    input  logic [IW-1:0]    i_rd_idx,
    output logic [WIDTH-1:0] o_rd_data,
    output logic [WIDTH-1:0] o_newest,
    output logic [CW-1:0]    o_count,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_ovf
);

    // Storage is kept as a shift array: slot 0 is always the oldest valid
    // entry, so rd_idx maps straight onto a slot in both full modes.
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic             r_ovf;

    logic             w_full;
    logic             w_empty;
    logic [WIDTH-1:0] w_rd_data;
    logic [WIDTH-1:0] w_newest;

    // Flags are pure decodes of the count, so they can never disagree.
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // State update: reset > clr > push; every register holds unless written.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (i_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (i_push) begin
            if (!w_full) begin
                // Append at the first free slot.
                for (int i = 0; i < DEPTH; i++) begin
                    if (CW'(i) == r_count) begin
                        r_mem[i] <= i_d;
                    end
                end
                r_count <= r_count + CW'(1);
            end else begin
                r_ovf <= 1'b1;
                if (FULL_MODE) begin
                    // Rolling history: drop slot 0, shift down, append at top.
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        r_mem[i] <= r_mem[i+1];
                    end
                    r_mem[DEPTH-1] <= i_d;
                end
            end
        end
    end

    // Indexed read: an index at or beyond the count (including indices past
    // DEPTH when DEPTH is not a power of two) reads as zero.
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((IW'(i) == i_rd_idx) && (CW'(i) < r_count)) begin
                w_rd_data = r_mem[i];
            end
        end
    end

    // Newest entry sits at slot count-1; zero when the history is empty.
    always_comb begin
        w_newest = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i + 1) == r_count) begin
                w_newest = r_mem[i];
            end
        end
    end

    assign o_rd_data = w_rd_data;
    assign o_newest  = w_newest;
    assign o_count   = r_count;
    assign o_empty   = w_empty;
    assign o_full    = w_full;
    assign o_ovf     = r_ovf;

endmodule

// File: tb/tb_guess_history.sv
// Bench for guess_history: one drop-mode and one rolling-mode instance share
// the same stimulus. A reference model (one queue per mode) produces the
// expected outputs, which are queued when a step is driven and popped when
// the DUT outputs are sampled one time unit after the clock edge.
module tb_guess_history;

    localparam int WIDTH = 4;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int IW    = $clog2(DEPTH);

    logic             clk;
    logic             reset;
    logic             clr;
    logic             push;
    logic [WIDTH-1:0] d;
    logic [IW-1:0]    rd_idx;

    logic [WIDTH-1:0] rd_data0, newest0, rd_data1, newest1;
    logic [CW-1:0]    count0, count1;
    logic             empty0, full0, ovf0, empty1, full1, ovf1;

    int total = 0;
    int bad   = 0;

    logic [7:0]       exp_q[$];
    logic [WIDTH-1:0] m0[$];
    logic [WIDTH-1:0] m1[$];
    bit               movf0, movf1;

    guess_history #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FULL_MODE(1'b0)) dut0 (
        .i_clk(clk), .i_reset(reset), .i_clr(clr), .i_push(push), .i_d(d),
        .i_rd_idx(rd_idx), .o_rd_data(rd_data0), .o_newest(newest0),
        .o_count(count0), .o_empty(empty0), .o_full(full0), .o_ovf(ovf0)
    );

    guess_history #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FULL_MODE(1'b1)) dut1 (
        .i_clk(clk), .i_reset(reset), .i_clr(clr), .i_push(push), .i_d(d),
        .i_rd_idx(rd_idx), .o_rd_data(rd_data1), .o_newest(newest1),
        .o_count(count1), .o_empty(empty1), .o_full(full1), .o_ovf(ovf1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    task automatic model_reset();
        m0.delete();
        m1.delete();
        movf0 = 1'b0;
        movf1 = 1'b0;
    endtask

    task automatic model_step(input logic p, input logic [WIDTH-1:0] v, input logic c);
        if (c) begin
            model_reset();
        end else if (p) begin
            if (m0.size() < DEPTH) m0.push_back(v);
            else movf0 = 1'b1;
            if (m1.size() < DEPTH) m1.push_back(v);
            else begin
                movf1 = 1'b1;
                void'(m1.pop_front());
                m1.push_back(v);
            end
        end
    endtask

    function automatic logic [7:0] q_at(input logic [WIDTH-1:0] q[$], input int idx);
        if (idx < q.size()) return 8'(q[idx]);
        return 8'h0;
    endfunction

    function automatic logic [7:0] q_newest(input logic [WIDTH-1:0] q[$]);
        if (q.size() > 0) return 8'(q[q.size()-1]);
        return 8'h0;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic sb_push_all();
        exp_q.push_back(8'(m0.size()));
        exp_q.push_back(8'(m0.size() == 0));
        exp_q.push_back(8'(m0.size() == DEPTH));
        exp_q.push_back(8'(movf0));
        exp_q.push_back(q_newest(m0));
        exp_q.push_back(q_at(m0, int'(rd_idx)));
        exp_q.push_back(8'(m1.size()));
        exp_q.push_back(8'(m1.size() == 0));
        exp_q.push_back(8'(m1.size() == DEPTH));
        exp_q.push_back(8'(movf1));
        exp_q.push_back(q_newest(m1));
        exp_q.push_back(q_at(m1, int'(rd_idx)));
    endtask

    task automatic sb_cmp(input string tag, input logic [7:0] obs);
        logic [7:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: expected queue empty, observed %0h", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
            end
        end
    endtask

    task automatic sb_cmp_all(input string tag);
        sb_cmp({tag, ".m0.count"},  8'(count0));
        sb_cmp({tag, ".m0.empty"},  8'(empty0));
        sb_cmp({tag, ".m0.full"},   8'(full0));
        sb_cmp({tag, ".m0.ovf"},    8'(ovf0));
        sb_cmp({tag, ".m0.newest"}, 8'(newest0));
        sb_cmp({tag, ".m0.rd"},     8'(rd_data0));
        sb_cmp({tag, ".m1.count"},  8'(count1));
        sb_cmp({tag, ".m1.empty"},  8'(empty1));
        sb_cmp({tag, ".m1.full"},   8'(full1));
        sb_cmp({tag, ".m1.ovf"},    8'(ovf1));
        sb_cmp({tag, ".m1.newest"}, 8'(newest1));
        sb_cmp({tag, ".m1.rd"},     8'(rd_data1));
    endtask

    // Fixed values straight from the game-level expectations.
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic step(input string tag, input logic p, input logic [WIDTH-1:0] v, input logic c);
        push = p;
        d    = v;
        clr  = c;
        model_step(p, v, c);
        sb_push_all();
        @(posedge clk);
        #1;
        sb_cmp_all(tag);
        push = 1'b0;
        clr  = 1'b0;
    endtask

    task automatic read_at(input string tag, input logic [IW-1:0] idx);
        rd_idx = idx;
        sb_push_all();
        #1;
        sb_cmp_all(tag);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset  = 1'b1;
        clr    = 1'b0;
        push   = 1'b0;
        d      = '0;
        rd_idx = '0;
        model_reset();

        // Reset without any clock edge yet.
        #2;
        sb_push_all();
        sb_cmp_all("reset");
        @(negedge clk);
        reset = 1'b0;

        // Fill with 1..8.
        for (int i = 1; i <= DEPTH; i++) begin
            step($sformatf("fill%0d", i), 1'b1, WIDTH'(i), 1'b0);
        end
        chk("fill.count", 8'(count0), 8'd8);
        chk("fill.full", 8'(full0), 8'd1);
        read_at("fill.r0", 3'd0);
        chk("fill.r0.const", 8'(rd_data0), 8'h1);
        read_at("fill.r7", 3'd7);
        chk("fill.r7.const", 8'(rd_data0), 8'h8);
        chk("fill.newest.const", 8'(newest0), 8'h8);

        // Push while full: drop vs roll.
        step("full.pushA", 1'b1, 4'hA, 1'b0);
        step("full.pushB", 1'b1, 4'hB, 1'b0);
        read_at("full.r0", 3'd0);
        chk("drop.r0.const", 8'(rd_data0), 8'h1);
        chk("roll.r0.const", 8'(rd_data1), 8'h3);
        read_at("full.r7", 3'd7);
        chk("roll.r7.const", 8'(rd_data1), 8'hB);
        chk("drop.newest.const", 8'(newest0), 8'h8);
        chk("roll.newest.const", 8'(newest1), 8'hB);
        chk("drop.ovf.const", 8'(ovf0), 8'd1);

        // Clear beats a simultaneous push at count=5.
        step("clr0", 1'b0, 4'h0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step($sformatf("refill%0d", i), 1'b1, WIDTH'($urandom_range(0, 15)), 1'b0);
        end
        read_at("refill.r4", 3'd4);
        step("clr_push", 1'b1, 4'hF, 1'b1);
        chk("clr.count.const", 8'(count0), 8'd0);
        chk("clr.empty.const", 8'(empty1), 8'd1);

        // Three entries, then idle with d toggling.
        for (int i = 0; i < 3; i++) begin
            step($sformatf("three%0d", i), 1'b1, WIDTH'($urandom_range(0, 15)), 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            step($sformatf("idle%0d", i), 1'b0, WIDTH'($urandom_range(0, 15)), 1'b0);
        end
        read_at("bounds.r2", 3'd2);
        read_at("bounds.r5", 3'd5);
        chk("bounds.r5.const", 8'(rd_data0), 8'h0);

        // Asynchronous reset pulsed while a push is pending.
        push = 1'b1;
        d    = 4'h7;
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        sb_push_all();
        sb_cmp_all("midreset");
        #1;
        reset = 1'b0;
        push  = 1'b0;
        step("after_reset", 1'b1, 4'h9, 1'b0);
        read_at("after_reset.r0", 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net: the sequence is bounded, but never let the run hang.
    initial begin
        #50000;
        bad++;
        $display("FAIL timeout: sequence did not complete, observed time %0t", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
